lift_travel_timer: RTL and testbench



---
 rtl/lift_travel_timer_if.sv | 32 +++
 rtl/lift_travel_timer.sv | 167 ++++++++++++++++
 tb/tb_lift_travel_timer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_travel_timer_if.sv
// -----------------------------------------------------------------------------
// lift_travel_timer_if
//   Bundle between the lift controller and the travel timer.
//   Controller -> timer : current_state (3b state code), nfloor (live target
//                         floor), pfloor (present floor).
//   Timer -> controller : reached (one-cycle arrival pulse), pos_floor (live car
//                         position), moving (travelling), fault (sticky error).
//   Handshake: there is no valid/ready pair. The controller presents its state
//   every cycle and the timer samples it on every rising clk edge; reached is
//   the only acknowledgement and is asserted for exactly one cycle per arrival.
// -----------------------------------------------------------------------------
interface lift_travel_timer_if;
   logic [2:0] current_state;
   logic [3:0] nfloor;
   logic [3:0] pfloor;
   logic       reached;
   logic [3:0] pos_floor;
   logic       moving;
   logic       fault;

   // Controller side
   modport master (
      output current_state, nfloor, pfloor,
      input  reached, pos_floor, moving, fault
   );

   // Timer side
   modport slave (
      input  current_state, nfloor, pfloor,
      output reached, pos_floor, moving, fault
   );
endinterface

// File: rtl/lift_travel_timer.sv
// -----------------------------------------------------------------------------
// lift_travel_timer
//   Models car travel for the lift controller at FLOOR_CYCLES clocks per floor.
//   On a move command from IDLE it checks the command for consistency, then
//   steps pos_floor one floor every FLOOR_CYCLES edges until it lands on the
//   live target, where it returns a single-cycle reached pulse. Inconsistent
//   commands drive a sticky fault that only rst clears.
//
//   Ports
//     clk          : system clock, rising edge
//     rst          : asynchronous active-high reset
//     ctl          : slave side of lift_travel_timer_if (see interface file)
//     dbg_state_o  : current FSM state (IDLE=0, TRAVEL=1, ARRIVE=2, FAULT=3)
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module lift_travel_timer #(
   parameter int FLOOR_CYCLES    = 8,
   parameter int NUM_FLOORS      = 11,
   parameter int STATE_MOVE_UP   = 4,
   parameter int STATE_MOVE_DOWN = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   lift_travel_timer_if.slave    ctl,
   output logic [1:0]            dbg_state_o
);

   localparam int         CW         = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FLOOR_CYCLES - 1);
   localparam logic [3:0] LAST_FLOOR = 4'(NUM_FLOORS - 1);
   localparam logic [2:0] CODE_UP    = 3'(STATE_MOVE_UP);
   localparam logic [2:0] CODE_DOWN  = 3'(STATE_MOVE_DOWN);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRAVEL = 2'd1,
      ST_ARRIVE = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;      // 1 = up, 0 = down
   logic [3:0]    pos_q, pos_d;
   logic          reached_q, reached_d;
   logic          moving_q, moving_d;
   logic          fault_q, fault_d;

   logic          is_up, is_down;
   logic [3:0]    pos_step;
   logic          step_out_of_range;
   logic          step_passes;

   assign is_up   = (ctl.current_state == CODE_UP);
   assign is_down = (ctl.current_state == CODE_DOWN);

   // Candidate position for the next floor step and the checks made on it.
   assign pos_step          = dir_q ? (pos_q + 4'd1) : (pos_q - 4'd1);
   assign step_out_of_range = dir_q ? (pos_q >= LAST_FLOOR) : (pos_q == 4'd0);
   assign step_passes       = dir_q ? (pos_step > ctl.nfloor) : (pos_step < ctl.nfloor);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dir_q     <= 1'b1;
         pos_q     <= 4'd0;
         reached_q <= 1'b0;
         moving_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         pos_q     <= pos_d;
         reached_q <= reached_d;
         moving_q  <= moving_d;
         fault_q   <= fault_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      pos_d   = pos_q;

      case (state_q)
         ST_IDLE: begin
            // Car position tracks the controller while parked.
            pos_d = ctl.pfloor;
            cnt_d = '0;
            if (is_up) begin
               dir_d = 1'b1;
               if ((ctl.nfloor <= ctl.pfloor) || (ctl.nfloor > LAST_FLOOR))
                  state_d = ST_FAULT;
               else
                  state_d = ST_TRAVEL;
            end else if (is_down) begin
               dir_d = 1'b0;
               if ((ctl.nfloor >= ctl.pfloor) || (ctl.nfloor > LAST_FLOOR))
                  state_d = ST_FAULT;
               else
                  state_d = ST_TRAVEL;
            end
         end

         ST_TRAVEL: begin
            if (!is_up && !is_down) begin
               // Abort: position holds this edge and resyncs from IDLE next edge.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if ((is_up && !dir_q) || (is_down && dir_q)) begin
               state_d = ST_FAULT;
            end else if (cnt_q == CNT_LAST) begin
               if (step_out_of_range || step_passes) begin
                  state_d = ST_FAULT;
               end else begin
                  cnt_d = '0;
                  pos_d = pos_step;
                  // nfloor is live, so a mid-trip target change is honoured here.
                  if (pos_step == ctl.nfloor)
                     state_d = ST_ARRIVE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_ARRIVE: begin
            cnt_d = '0;
            // Holding in ARRIVE while the move code persists stops a re-pulse.
            if (!is_up && !is_down)
               state_d = ST_IDLE;
         end

         ST_FAULT: begin
            // Sticky until rst; position frozen.
         end

         default: state_d = ST_FAULT;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic (registered through the state register process)
   // ---------------------------------------------------------------------------
   always_comb begin
      reached_d = (state_q == ST_TRAVEL) && (state_d == ST_ARRIVE);
      moving_d  = (state_d == ST_TRAVEL);
      fault_d   = (state_d == ST_FAULT);
   end

   assign ctl.reached   = reached_q;
   assign ctl.pos_floor = pos_q;
   assign ctl.moving    = moving_q;
   assign ctl.fault     = fault_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lift_travel_timer.sv
// -----------------------------------------------------------------------------
// tb_lift_travel_timer
//   Self-checking bench for lift_travel_timer with FLOOR_CYCLES=4. Expected car
//   position and pulse timing come from arithmetic on the trip: k edges after
//   the entry edge the car is floor(k/FLOOR_CYCLES) floors from the start, and
//   reached is high only at k == FLOOR_CYCLES*distance.
// -----------------------------------------------------------------------------
module tb_lift_travel_timer;

   localparam int FC    = 4;
   localparam int NF    = 11;
   localparam logic [2:0] UP   = 3'd4;
   localparam logic [2:0] DOWN = 3'd5;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         tests_run;
   int         tests_failed;

   lift_travel_timer_if bus ();

   lift_travel_timer #(
      .FLOOR_CYCLES    (FC),
      .NUM_FLOORS      (NF),
      .STATE_MOVE_UP   (4),
      .STATE_MOVE_DOWN (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ctl         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Drives one full trip p -> n and checks every edge from entry to hold.
   task automatic run_trip(input logic [3:0] p, input logic [3:0] n, input int hold);
      logic up;
      int d, total;
      logic [3:0] exp_pos;
      up    = (n > p);
      d     = up ? int'(n) - int'(p) : int'(p) - int'(n);
      total = FC * d;
      bus.pfloor        = p;
      bus.nfloor        = n;
      bus.current_state = up ? UP : DOWN;
      for (int k = 0; k <= total + hold; k++) begin
         tick();
         if (k >= total) exp_pos = n;
         else            exp_pos = up ? 4'(int'(p) + k / FC) : 4'(int'(p) - k / FC);
         tests_run++;
         if (bus.pos_floor !== exp_pos || bus.reached !== (k == total) ||
             bus.moving !== (k < total) || bus.fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL trip %0d->%0d k=%0d: pos=%0d reached=%b moving=%b fault=%b, want pos=%0d reached=%b moving=%b fault=0",
                     p, n, k, bus.pos_floor, bus.reached, bus.moving, bus.fault,
                     exp_pos, (k == total), (k < total));
         end
      end
      // Controller leaves the move state and adopts the new floor.
      bus.current_state = 3'd1;
      bus.pfloor        = n;
      tick();
      tick();
      tests_run++;
      if (bus.moving !== 1'b0 || bus.reached !== 1'b0 || bus.pos_floor !== n) begin
         tests_failed++;
         $display("FAIL trip_idle %0d->%0d: moving=%b reached=%b pos=%0d, want 0 0 %0d",
                  p, n, bus.moving, bus.reached, bus.pos_floor, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.current_state = 3'd0;
      bus.nfloor = 4'd0;
      bus.pfloor = 4'd0;
      #1;
      tests_run++;
      if (bus.reached !== 1'b0 || bus.pos_floor !== 4'd0 || bus.moving !== 1'b0 || bus.fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: reached=%b pos=%0d moving=%b fault=%b, want all 0",
                  bus.reached, bus.pos_floor, bus.moving, bus.fault);
      end
      tick();
      tick();
      rst = 1'b0;
      bus.current_state = 3'd3;
      bus.pfloor = 4'd2;
      bus.nfloor = 4'd5;
      tick();
   endtask

   task automatic test_up_trip();
      run_trip(4'd2, 4'd5, 2);
   endtask

   task automatic test_down_trip();
      run_trip(4'd7, 4'd6, 3);
   endtask

   task automatic test_extension();
      logic [3:0] exp_pos;
      bus.pfloor = 4'd0;
      bus.nfloor = 4'd3;
      bus.current_state = UP;
      for (int k = 0; k <= 34; k++) begin
         tick();
         exp_pos = (k >= 32) ? 4'd8 : 4'(k / FC);
         tests_run++;
         if (bus.pos_floor !== exp_pos || bus.reached !== (k == 32) || bus.fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL extension k=%0d: pos=%0d reached=%b fault=%b, want pos=%0d reached=%b fault=0",
                     k, bus.pos_floor, bus.reached, bus.fault, exp_pos, (k == 32));
         end
         if (k == 8) bus.nfloor = 4'd8;
      end
      bus.current_state = 3'd1;
      bus.pfloor = 4'd8;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] p, n;
      for (int t = 0; t < 8; t++) begin
         p = 4'($urandom_range(0, NF - 1));
         do n = 4'($urandom_range(0, NF - 1)); while (n == p);
         run_trip(p, n, $urandom_range(0, 2));
      end
   endtask

   task automatic test_abort();
      bus.pfloor = 4'd1;
      bus.nfloor = 4'd6;
      bus.current_state = UP;
      for (int k = 0; k <= 5; k++) tick();
      bus.current_state = 3'd3;
      bus.pfloor = 4'd9;
      tick();
      tests_run++;
      if (bus.moving !== 1'b0 || bus.reached !== 1'b0 || bus.fault !== 1'b0 || bus.pos_floor !== 4'd2) begin
         tests_failed++;
         $display("FAIL abort_edge: moving=%b reached=%b fault=%b pos=%0d, want 0 0 0 2",
                  bus.moving, bus.reached, bus.fault, bus.pos_floor);
      end
      tick();
      tests_run++;
      if (bus.pos_floor !== 4'd9 || bus.moving !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_resync: pos=%0d moving=%b, want 9 0", bus.pos_floor, bus.moving);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      bus.pfloor = 4'd3;
      bus.nfloor = 4'd9;
      bus.current_state = UP;
      for (int k = 0; k <= 9; k++) tick();
      #2;
      rst = 1'b1;
      bus.current_state = 3'd1;
      #1;
      tests_run++;
      if (bus.reached !== 1'b0 || bus.pos_floor !== 4'd0 || bus.moving !== 1'b0 || bus.fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: reached=%b pos=%0d moving=%b fault=%b, want all 0",
                  bus.reached, bus.pos_floor, bus.moving, bus.fault);
      end
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.reached === 1'b1 || bus.moving === 1'b1) pulses++;
      end
      tests_run++;
      if (pulses != 0 || bus.pos_floor !== 4'd3) begin
         tests_failed++;
         $display("FAIL reset_mid_after: activity=%0d pos=%0d, want 0 3", pulses, bus.pos_floor);
      end
   endtask

   task automatic test_bad_command();
      logic [3:0] bp[3];
      logic [3:0] bn[3];
      logic [2:0] bs[3];
      int seen;
      bp[0] = 4'd4; bn[0] = 4'd4;  bs[0] = UP;
      bp[1] = 4'd3; bn[1] = 4'd12; bs[1] = UP;
      bp[2] = 4'd2; bn[2] = 4'd6;  bs[2] = DOWN;
      for (int c = 0; c < 3; c++) begin
         bus.current_state = 3'd1;
         bus.pfloor = bp[c];
         bus.nfloor = bn[c];
         tick();
         bus.current_state = bs[c];
         tick();
         tests_run++;
         if (bus.fault !== 1'b1 || bus.moving !== 1'b0 || bus.reached !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_cmd_%0d entry: fault=%b moving=%b reached=%b, want 1 0 0",
                     c, bus.fault, bus.moving, bus.reached);
         end
         seen = 0;
         bus.current_state = 3'd1;
         for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.reached === 1'b1 || bus.fault !== 1'b1) seen++;
         end
         tests_run++;
         if (seen != 0) begin
            tests_failed++;
            $display("FAIL bad_cmd_%0d held: bad cycles=%0d, want 0", c, seen);
         end
         bus.pfloor = 4'd0;
         pulse_reset();
         tests_run++;
         if (bus.fault !== 1'b0 || bus.reached !== 1'b0 || bus.moving !== 1'b0 || bus.pos_floor !== 4'd0) begin
            tests_failed++;
            $display("FAIL bad_cmd_%0d cleared: fault=%b reached=%b moving=%b pos=%0d, want all 0",
                     c, bus.fault, bus.reached, bus.moving, bus.pos_floor);
         end
      end
   endtask

   task automatic test_flip();
      int bad;
      bus.pfloor = 4'd2;
      bus.nfloor = 4'd7;
      bus.current_state = UP;
      for (int k = 0; k <= 5; k++) tick();
      bus.current_state = DOWN;
      tick();
      tests_run++;
      if (bus.fault !== 1'b1 || bus.moving !== 1'b0 || bus.pos_floor !== 4'd3) begin
         tests_failed++;
         $display("FAIL flip: fault=%b moving=%b pos=%0d, want 1 0 3",
                  bus.fault, bus.moving, bus.pos_floor);
      end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.pos_floor !== 4'd3 || bus.fault !== 1'b1 || bus.reached !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL flip_frozen: bad cycles=%0d, want 0", bad);
      end
      bus.current_state = 3'd1;
      bus.pfloor = 4'd0;
      pulse_reset();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_up_trip();
      test_down_trip();
      test_extension();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_bad_command();
      test_flip();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
